// File: rtl/geig_packet_framer_pkg.sv
// -----------------------------------------------------------------------------
// geig_pkg
// Shared constants, FSM state encoding and payload byte selection for the
// geiger telemetry framer.
//
// A data stack is {counts[15:0], timestamp[23:0], id[7:0]} = 48 bits. It
// leaves the framer as the 9-byte frame SYNC0, SYNC1, six payload bytes
// MSB-first, then the modulo-256 sum of those six payload bytes.
// -----------------------------------------------------------------------------
package geig_pkg;

    localparam int          STACK_W     = 48;
    localparam int          FRAME_LEN   = 9;
    localparam int          PAYLOAD_LEN = 6;
    localparam logic [7:0]  GEIG_ID     = 8'h47;
    localparam logic [7:0]  SYNC0_DEF   = 8'hAA;
    localparam logic [7:0]  SYNC1_DEF   = 8'h55;

    // Most significant bit of each field within the stack.
    localparam int          COUNTS_MSB  = 47;
    localparam int          TS_MSB      = 31;
    localparam int          ID_MSB      = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC_A  = 3'd1,
        SYNC_B  = 3'd2,
        PAYLOAD = 3'd3,
        CKSUM   = 3'd4
    } geig_state_t;

    // Payload byte idx (0..5) in transmit order:
    // counts hi, counts lo, ts[23:16], ts[15:8], ts[7:0], id.
    function automatic logic [7:0] payload_byte(input logic [STACK_W-1:0] s,
                                                input logic [2:0]         idx);
        case (idx)
            3'd0:    payload_byte = s[COUNTS_MSB     -: 8];
            3'd1:    payload_byte = s[COUNTS_MSB - 8 -: 8];
            3'd2:    payload_byte = s[TS_MSB         -: 8];
            3'd3:    payload_byte = s[TS_MSB - 8     -: 8];
            3'd4:    payload_byte = s[TS_MSB - 16    -: 8];
            default: payload_byte = s[ID_MSB         -: 8];
        endcase
    endfunction

endpackage

// File: rtl/geig_packet_framer_if.sv
// -----------------------------------------------------------------------------
// geig_packet_framer_if
// Bundles the stack push strobe and the byte output handshake of the framer.
//
//   STACK_IN[47:0]  stack data, meaningful only while STACK_VALID=1
//   STACK_VALID     one-cycle push strobe
//   TX_BYTE[7:0]    current frame byte
//   TX_VALID        TX_BYTE is valid
//   TX_READY        downstream accepts TX_BYTE this cycle
//
// Handshake: a byte moves on a rising edge where TX_VALID=1 and TX_READY=1.
// While TX_VALID=1 and TX_READY=0 the producer holds TX_BYTE and TX_VALID
// unchanged; TX_VALID does not depend on TX_READY and stays high for the
// whole frame.
//
// master: the side that pushes stacks and consumes bytes.
// slave : the framer.
// -----------------------------------------------------------------------------
interface geig_packet_framer_if;
    import geig_pkg::*;

    logic [STACK_W-1:0] STACK_IN;
    logic               STACK_VALID;
    logic [7:0]         TX_BYTE;
    logic               TX_VALID;
    logic               TX_READY;

    modport master (output STACK_IN, STACK_VALID, TX_READY,
                    input  TX_BYTE, TX_VALID);
    modport slave  (input  STACK_IN, STACK_VALID, TX_READY,
                    output TX_BYTE, TX_VALID);
endinterface

// File: rtl/geig_stack_fifo.sv
// -----------------------------------------------------------------------------
// geig_stack_fifo
// Synchronous FIFO for data stacks. DEPTH must be a power of two so the
// pointers wrap naturally.
//
//   clk, rst       clock, synchronous active-high reset (empties the FIFO)
//   push, din      write request / data
//   pop, dout      read request / head entry (dout valid while !empty)
//   full, empty    derived from the registered level
//   level          number of entries stored, 0..DEPTH
//
// A push while full is accepted only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module geig_stack_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 48,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] level_q;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/geig_packet_framer.sv
// -----------------------------------------------------------------------------
// geig_packet_framer
// Buffers 48-bit geiger stacks and serialises each into a 9-byte frame:
// SYNC0, SYNC1, counts[15:8], counts[7:0], ts[23:16], ts[15:8], ts[7:0],
// id, checksum (modulo-256 sum of the six payload bytes).
//
//   CLK_100KHZ     sole clock, rising edge
//   RESET          synchronous active-high reset; abandons any frame
//   bus (slave)    STACK_IN/STACK_VALID push, TX_BYTE/TX_VALID/TX_READY out
//   FIFO_OVERFLOW  sticky, set when a stack is dropped
//   DROP_COUNT     dropped stacks, saturating at 8'hFF
//   FIFO_LEVEL     stacks waiting in the FIFO (the frame in flight excluded)
//   FSM_STATE      current framer state, for observation
//
// All outputs are registered. A frame's stack is popped from the FIFO when
// the frame starts, so back-to-back frames follow with no idle cycle.
// -----------------------------------------------------------------------------
module geig_packet_framer
    import geig_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC0      = SYNC0_DEF,
    parameter logic [7:0] SYNC1      = SYNC1_DEF
) (
    input  logic                        CLK_100KHZ,
    input  logic                        RESET,
    geig_packet_framer_if.slave         bus,
    output logic                        FIFO_OVERFLOW,
    output logic [7:0]                  DROP_COUNT,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output geig_state_t                 FSM_STATE
);

    logic [STACK_W-1:0] fifo_head;
    logic               fifo_full, fifo_empty, fifo_pop;

    geig_stack_fifo #(.DEPTH(FIFO_DEPTH), .W(STACK_W)) u_fifo (
        .clk   (CLK_100KHZ),
        .rst   (RESET),
        .push  (bus.STACK_VALID),
        .din   (bus.STACK_IN),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

    geig_state_t        state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [STACK_W-1:0] stack_q, stack_d;
    logic [7:0]         cksum_q, cksum_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_valid_q, tx_valid_d;
    logic               xfer, drop;

    assign xfer          = tx_valid_q && bus.TX_READY;
    // A push into a full FIFO survives only if the framer pops this cycle.
    assign drop          = bus.STACK_VALID && fifo_full && !fifo_pop;
    assign bus.TX_BYTE   = tx_byte_q;
    assign bus.TX_VALID  = tx_valid_q;
    assign FSM_STATE     = state_q;

    always_ff @(posedge CLK_100KHZ) begin
        if (RESET) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            stack_q       <= '0;
            cksum_q       <= '0;
            tx_byte_q     <= '0;
            tx_valid_q    <= 1'b0;
            FIFO_OVERFLOW <= 1'b0;
            DROP_COUNT    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            stack_q    <= stack_d;
            cksum_q    <= cksum_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            if (drop) begin
                FIFO_OVERFLOW <= 1'b1;
                if (DROP_COUNT != 8'hFF) DROP_COUNT <= DROP_COUNT + 8'd1;
            end
        end
    end

    // Next-state logic computes the byte to present after each edge, so the
    // registered TX_BYTE already holds the right value when the state changes.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stack_d    = stack_q;
        cksum_d    = cksum_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    stack_d    = fifo_head;
                    cksum_d    = '0;
                    state_d    = SYNC_A;
                    tx_byte_d  = SYNC0;
                    tx_valid_d = 1'b1;
                end
            end
            SYNC_A: begin
                if (xfer) begin
                    state_d   = SYNC_B;
                    tx_byte_d = SYNC1;
                end
            end
            SYNC_B: begin
                if (xfer) begin
                    state_d   = PAYLOAD;
                    idx_d     = 3'd0;
                    tx_byte_d = payload_byte(stack_q, 3'd0);
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    cksum_d = cksum_q + tx_byte_q;
                    if (idx_q == 3'(PAYLOAD_LEN - 1)) begin
                        state_d   = CKSUM;
                        tx_byte_d = cksum_q + tx_byte_q;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_byte_d = payload_byte(stack_q, idx_q + 3'd1);
                    end
                end
            end
            CKSUM: begin
                if (xfer) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        stack_d    = fifo_head;
                        cksum_d    = '0;
                        state_d    = SYNC_A;
                        tx_byte_d  = SYNC0;
                    end else begin
                        state_d    = IDLE;
                        tx_byte_d  = '0;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_geig_packet_framer.sv
// -----------------------------------------------------------------------------
// tb_geig_packet_framer
// Directed bench for geig_packet_framer. A frame-level model (queue of stacks
// waiting, queue of bytes left in the current frame) predicts TX_VALID,
// TX_BYTE, FIFO_LEVEL, FIFO_OVERFLOW and DROP_COUNT every cycle; literal
// expectations from hand-computed frames pin the model.
// -----------------------------------------------------------------------------
module tb_geig_packet_framer;
    import geig_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    geig_packet_framer_if bus();

    logic        ovf;
    logic [7:0]  drops;
    logic [2:0]  level;
    geig_state_t st;

    geig_packet_framer #(
        .FIFO_DEPTH (DEPTH),
        .SYNC0      (8'hAA),
        .SYNC1      (8'h55)
    ) dut (
        .CLK_100KHZ    (clk),
        .RESET         (rst),
        .bus           (bus),
        .FIFO_OVERFLOW (ovf),
        .DROP_COUNT    (drops),
        .FIFO_LEVEL    (level),
        .FSM_STATE     (st)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    logic [47:0] m_pend[$];   // stacks waiting in the FIFO
    logic [7:0]  exp_q[$];    // bytes still to send in the current frame
    logic [7:0]  got_q[$];    // bytes actually transferred
    bit          m_ovf;
    int          m_drops;
    bit          chk_en = 1'b0;
    bit          busy, xfer, finishing, full, pop, accept;

    function automatic void load_frame(input logic [47:0] s);
        logic [7:0] b, sum;
        sum = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 6; i++) begin
            b = s[47 - 8*i -: 8];
            sum = sum + b;
            exp_q.push_back(b);
        end
        exp_q.push_back(sum);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            busy = (exp_q.size() > 0);
            check("tx_valid", bus.TX_VALID, busy);
            if (busy) check("tx_byte", bus.TX_BYTE, exp_q[0]);
            check("fifo_level", level, m_pend.size());
            check("fifo_overflow", ovf, m_ovf);
            check("drop_count", drops, m_drops);
            if (bus.TX_VALID && bus.TX_READY) got_q.push_back(bus.TX_BYTE);

            // advance the model across the coming rising edge
            if (rst) begin
                m_pend.delete();
                exp_q.delete();
                m_ovf   = 1'b0;
                m_drops = 0;
            end else begin
                xfer      = busy && bus.TX_READY;
                finishing = xfer && (exp_q.size() == 1);
                full      = (m_pend.size() == DEPTH);
                pop       = (m_pend.size() > 0) && (!busy || finishing);
                if (xfer) void'(exp_q.pop_front());
                accept    = bus.STACK_VALID && (!full || pop);
                if (bus.STACK_VALID && !accept) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
                if (pop) load_frame(m_pend.pop_front());
                if (accept) m_pend.push_back(bus.STACK_IN);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] s);
        bus.STACK_IN    = s;
        bus.STACK_VALID = 1'b1;
        tick();
        bus.STACK_VALID = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [7:0] f [9]);
        check({name, "_len"}, got_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < got_q.size()) check(name, got_q[i], f[i]);
        end
    endtask

    localparam logic [47:0] S1 = {16'h0123, 24'h00ABCD, 8'h47};
    localparam logic [47:0] S2 = {16'h1122, 24'h334455, 8'h47};

    logic [7:0] f1 [9] = '{8'hAA, 8'h55, 8'h01, 8'h23, 8'h00, 8'hAB, 8'hCD, 8'h47, 8'hE3};
    logic [7:0] f2 [9] = '{8'hAA, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h47, 8'h46};
    logic [7:0] cnt_exp [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07};

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.STACK_IN    = '0;
        bus.STACK_VALID = 1'b0;
        bus.TX_READY    = 1'b1;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", bus.TX_VALID, 1'b0);
        check("rst_tx_byte", bus.TX_BYTE, 8'h00);
        check("rst_level", level, 3'd0);
        check("rst_overflow", ovf, 1'b0);
        check("rst_drops", drops, 8'h00);
        chk_en = 1'b1;
        rst    = 1'b0;
        tick();

        // single frame, latency of two cycles to SYNC0
        got_q.delete();
        push(S1);
        check("lat_not_yet", bus.TX_VALID, 1'b0);
        tick();
        check("lat_valid", bus.TX_VALID, 1'b1);
        check("lat_sync0", bus.TX_BYTE, 8'hAA);
        repeat (12) tick();
        check_frame("frame1", f1);
        check("frame1_idle_after", bus.TX_VALID, 1'b0);

        // back-pressure on the AB byte
        got_q.delete();
        push(S1);
        n = 0;
        while (n < 20 && !(bus.TX_VALID && bus.TX_BYTE == 8'hAB)) begin
            tick();
            n++;
        end
        check("bp_reach_ab", n < 20, 1'b1);
        bus.TX_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_byte", bus.TX_BYTE, 8'hAB);
            check("bp_hold_valid", bus.TX_VALID, 1'b1);
        end
        bus.TX_READY = 1'b1;
        repeat (8) tick();
        check_frame("frame_bp", f1);

        // overflow with back-pressure, then push on full during a checksum pop
        got_q.delete();
        bus.TX_READY = 1'b0;
        for (int k = 1; k <= 6; k++) push({16'(k), 24'h000100 + 24'(k), 8'h47});
        tick();
        check("ovf_level", level, 3'd4);
        check("ovf_drops", drops, 8'd1);
        check("ovf_flag", ovf, 1'b1);
        bus.TX_READY = 1'b1;
        n = 0;
        while (n < 30 && st != CKSUM) begin
            tick();
            n++;
        end
        check("ovf_reach_cksum", n < 30, 1'b1);
        push({16'd7, 24'h000107, 8'h47});
        check("fullpop_drops", drops, 8'd1);
        check("fullpop_level", level, 3'd4);
        repeat (60) tick();
        check("ovf_bytes", got_q.size(), 54);
        for (int f = 0; f < 6; f++) begin
            if (9*f + 3 < got_q.size()) begin
                check("ovf_count_hi", got_q[9*f + 2], 8'h00);
                check("ovf_count_lo", got_q[9*f + 3], cnt_exp[f]);
            end
        end

        // reset during payload idx3
        got_q.delete();
        push(S1);
        push(S2);
        push(S2);
        n = 0;
        while (n < 20 && !(bus.TX_VALID && bus.TX_BYTE == 8'hAB)) begin
            tick();
            n++;
        end
        check("rst_mid_reach", n < 20, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", bus.TX_VALID, 1'b0);
        check("rst_mid_level", level, 3'd0);
        check("rst_mid_overflow", ovf, 1'b0);
        check("rst_mid_drops", drops, 8'd0);
        got_q.delete();
        push(S2);
        repeat (12) tick();
        check_frame("frame_after_rst", f2);

        // saturation: 1 in flight + 4 stored + 300 dropped
        bus.TX_READY = 1'b0;
        for (int k = 0; k < 305; k++) push({16'(k), 24'(k * 3), 8'h47});
        tick();
        check("sat_drops", drops, 8'hFF);
        check("sat_overflow", ovf, 1'b1);
        check("sat_level", level, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/geig_packet_framer.md
Name: geig_packet_framer

Overview:
- Downstream consumer of the 48-bit geiger data stack: {counts[15:0], timestamp[23:0], ID 8'h47}, one per minute.
- Buffers stacks in a small FIFO and serialises each one into a 9-byte telemetry frame.
- Frame layout: 2 sync bytes, 6 payload bytes MSB-first, 1 checksum byte.
- Frames are presented on a byte valid/ready interface to the downlink UART/radio stage.

Parameters:
- FIFO_DEPTH, 4, number of 48-bit stacks buffered (power of two, ≥2).
- SYNC0, 8'hAA, first frame sync byte.
- SYNC1, 8'h55, second frame sync byte.

Ports:
- CLK_100KHZ  in  1  sole clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- STACK_IN  in  48  data stack; valid only while STACK_VALID=1.
- STACK_VALID  in  1  one-cycle push strobe, synchronous to CLK_100KHZ.
- TX_READY  in  1  downstream accepts TX_BYTE this cycle.
- TX_BYTE  out  8  current frame byte.
- TX_VALID  out  1  TX_BYTE is valid.
- FIFO_OVERFLOW  out  1  sticky: a stack was dropped.
- DROP_COUNT  out  8  saturating count of dropped stacks.
- FIFO_LEVEL  out  3  stacks currently stored (0..FIFO_DEPTH).

Behaviour:
- Reset (sync, RESET=1 at an edge): TX_BYTE=0, TX_VALID=0, FIFO_OVERFLOW=0, DROP_COUNT=0, FIFO_LEVEL=0, FSM=IDLE, FIFO emptied. Reset mid-frame abandons the frame; no partial resumption.
- Transfer rule: a byte transfers on an edge where TX_VALID=1 and TX_READY=1. While TX_VALID=1 and TX_READY=0, TX_BYTE and TX_VALID are held stable. TX_VALID never drops mid-frame.
- FSM states: IDLE, SYNC_A, SYNC_B, PAYLOAD (byte index 0..5), CKSUM.
  - IDLE: if FIFO not empty, pop the head into a 48-bit shift register, clear the checksum, go to SYNC_A (TX_BYTE=SYNC0, TX_VALID=1).
  - SYNC_A → SYNC_B on transfer (TX_BYTE=SYNC1).
  - SYNC_B → PAYLOAD idx0 on transfer.
  - PAYLOAD order: counts[15:8], counts[7:0], ts[23:16], ts[15:8], ts[7:0], ID. Each transfer adds the byte to the checksum and advances the index; after idx5, go to CKSUM.
  - CKSUM: TX_BYTE = 8-bit modulo-256 sum of the 6 payload bytes. On transfer: if FIFO not empty, pop and go directly to SYNC_A (zero-gap frames); otherwise go to IDLE with TX_VALID=0.
- Latency: STACK_VALID in cycle n with FIFO empty and FSM in IDLE → TX_VALID=1, TX_BYTE=SYNC0 in cycle n+2.
- FIFO:
  - Push when STACK_VALID=1 and not full.
  - Push when full and no pop in the same cycle: stack discarded, FIFO_OVERFLOW←1 (cleared only by RESET), DROP_COUNT increments and saturates at 8'hFF.
  - Simultaneous push and pop when full: push accepted, level unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO_LEVEL is registered, updated one edge after push/pop.
- Payload is not inspected: the ID byte is passed through unchanged.
- All outputs are registered.

Decomposition:
- Shared package geig_pkg:
  - GEIG_ID=8'h47, STACK_W=48, FRAME_LEN=9, SYNC0/SYNC1 defaults.
  - Field slice constants: COUNTS_MSB=47, TS_MSB=31, ID_MSB=7.
  - FSM state encoding.
- One sub-module, geig_stack_fifo:
  - Parameterised synchronous FIFO with push, pop, full, empty, level.
  - The framer instantiates it and owns the FSM, shift register, checksum and drop logic.

Test Plan:
- Single frame, TX_READY=1: push {16'h0123, 24'h00ABCD, 8'h47} → bytes AA 55 01 23 00 AB CD 47 E3 on 9 consecutive cycles starting 2 cycles after the push; TX_VALID=0 afterwards.
- Back-pressure: same stack, TX_READY=0 for 5 cycles while TX_BYTE=8'hAB → TX_BYTE held at AB, TX_VALID=1; sequence resumes unchanged; checksum still E3.
- Overflow: hold TX_READY=0 and push 6 distinct stacks (counts 1..6) → first stack is popped into the FSM. Stacks 2..5 fill the FIFO (FIFO_LEVEL=4). Stack 6 is dropped (FIFO_OVERFLOW=1, DROP_COUNT=1). Releasing TX_READY yields 5 frames in order with counts 1..5, and no idle cycle between frames.
- Push on full with simultaneous pop: FIFO full, push in the same cycle CKSUM transfers → no drop; DROP_COUNT unchanged; FIFO_LEVEL stays 4.
- Reset mid-frame: assert RESET during PAYLOAD idx3 → next cycle TX_VALID=0, FIFO_LEVEL=0, FIFO_OVERFLOW=0; a new push produces a clean AA 55 … frame.
- Saturation: force 300 drops → DROP_COUNT=8'hFF, FIFO_OVERFLOW=1.
